// File: rtl/mat_loader_if.sv
// Streaming-load and multiplier-handshake bundle for mat_loader.
// The slave modport is the loader; the master modport is the producer/multiplier side.
interface mat_loader_if #(
  parameter int S = 32,
  parameter int H = 2,
  parameter int C = 2,
  parameter int W = 2
);
  logic             in_valid;
  logic             in_ready;
  logic [S-1:0]     in_data;
  logic             mm_start;
  logic             mm_done;
  logic [S*H*C-1:0] a;
  logic [S*C*W-1:0] b;
  logic             busy;
  logic [7:0]       frame_cnt;

  modport slave (
    input  in_valid, in_data, mm_done,
    output in_ready, mm_start, a, b, busy, frame_cnt
  );

  modport master (
    output in_valid, in_data, mm_done,
    input  in_ready, mm_start, a, b, busy, frame_cnt
  );
endinterface

// File: rtl/mat_loader.sv
// Collects a stream of float elements into packed matrices A and B, then fires the multiplier.
// Optional macro MAT_LOADER_TRANSPOSE_B_EN: the B stream arrives column-major instead of row-major.
module mat_loader #(
  parameter int S = 32,
  parameter int H = 2,
  parameter int C = 2,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  mat_loader_if.slave  bus
);

  localparam int HC   = H * C;
  localparam int CW   = C * W;
  localparam int NMAX = (HC > CW) ? HC : CW;
  localparam int NW   = $clog2(NMAX + 1);

  localparam logic [NW-1:0] A_LAST = NW'(HC - 1);
  localparam logic [NW-1:0] B_LAST = NW'(CW - 1);

  typedef enum logic [1:0] {
    ST_LOAD_A = 2'd0,
    ST_LOAD_B = 2'd1,
    ST_FIRE   = 2'd2,
    ST_WAIT   = 2'd3
  } state_t;

  state_t          r_state, w_state_next;
  logic [NW-1:0]   r_n, w_n_next;
  logic [S*HC-1:0] r_a;
  logic [S*CW-1:0] r_b;
  logic [7:0]      r_frame_cnt;
  logic            w_ready, w_start, w_busy, w_hs, w_frame_done;
  logic [HC-1:0]   w_a_we;
  logic [CW-1:0]   w_b_we;

  always_comb begin
    w_state_next = r_state;
    w_n_next     = r_n;
    w_ready      = 1'b0;
    w_start      = 1'b0;
    w_busy       = 1'b0;
    w_hs         = 1'b0;
    w_frame_done = 1'b0;
    case (r_state)
      ST_LOAD_A: begin
        w_ready = 1'b1;
        w_hs    = bus.in_valid;
        if (bus.in_valid) begin
          if (r_n == A_LAST) begin
            w_n_next     = '0;
            w_state_next = ST_LOAD_B;
          end else begin
            w_n_next = r_n + NW'(1);
          end
        end
      end
      ST_LOAD_B: begin
        w_ready = 1'b1;
        w_hs    = bus.in_valid;
        if (bus.in_valid) begin
          if (r_n == B_LAST) begin
            w_n_next     = '0;
            w_state_next = ST_FIRE;
          end else begin
            w_n_next = r_n + NW'(1);
          end
        end
      end
      ST_FIRE: begin
        w_start      = 1'b1;
        w_busy       = 1'b1;
        w_state_next = ST_WAIT;
      end
      ST_WAIT: begin
        w_busy = 1'b1;
        if (bus.mm_done) begin
          w_frame_done = 1'b1;
          w_state_next = ST_LOAD_A;
        end
      end
      default: w_state_next = ST_LOAD_A;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_LOAD_A;
      r_n         <= '0;
      r_frame_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      r_n     <= w_n_next;
      if (w_frame_done) r_frame_cnt <= r_frame_cnt + 8'd1;
    end
  end

  // Element index gi is counted from the MSB end of the packed bus.
  genvar gi;
  generate
    for (gi = 0; gi < HC; gi++) begin : g_a_we
      assign w_a_we[gi] = w_hs && (r_state == ST_LOAD_A) && (r_n == NW'(gi));
    end
    for (gi = 0; gi < CW; gi++) begin : g_b_we
`ifdef MAT_LOADER_TRANSPOSE_B_EN
      // Row-major slot k*W+j is fed by column-major handshake j*C+k.
      localparam int SLOT_N = (gi % W) * C + (gi / W);
`else
      localparam int SLOT_N = gi;
`endif
      assign w_b_we[gi] = w_hs && (r_state == ST_LOAD_B) && (r_n == NW'(SLOT_N));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a <= '0;
      r_b <= '0;
    end else begin
      for (int i = 0; i < HC; i++)
        if (w_a_we[i]) r_a[S*(HC-i)-1 -: S] <= bus.in_data;
      for (int i = 0; i < CW; i++)
        if (w_b_we[i]) r_b[S*(CW-i)-1 -: S] <= bus.in_data;
    end
  end

  assign bus.in_ready  = w_ready;
  assign bus.mm_start  = w_start;
  assign bus.busy      = w_busy;
  assign bus.a         = r_a;
  assign bus.b         = r_b;
  assign bus.frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_mat_loader.sv
// Directed self-checking bench for mat_loader at H=C=W=2, S=32.
module tb_mat_loader;
  localparam int S = 32;
  localparam int H = 2;
  localparam int C = 2;
  localparam int W = 2;

  localparam logic [127:0] EXP_A = 128'h3F800000_40000000_40400000_40800000;
`ifdef MAT_LOADER_TRANSPOSE_B_EN
  localparam logic [127:0] EXP_B      = 128'h40A00000_40E00000_40C00000_41000000;
  localparam logic [127:0] EXP_B_PART = 128'h40A00000_00000000_40C00000_00000000;
`else
  localparam logic [127:0] EXP_B      = 128'h40A00000_40C00000_40E00000_41000000;
  localparam logic [127:0] EXP_B_PART = 128'h40A00000_40C00000_00000000_00000000;
`endif

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  logic [31:0] stream_q [8];

  mat_loader_if #(.S(S), .H(H), .C(C), .W(W)) bus ();

  mat_loader #(.S(S), .H(H), .C(C), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.mm_done  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    tick();
  endtask

  task automatic run_frame();
    for (int i = 0; i < 8; i++) send_word(stream_q[i]);
    bus.in_valid = 1'b0;
    tick();
    bus.mm_done = 1'b1;
    tick();
    bus.mm_done = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hDEADBEEF;
    bus.mm_done  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (bus.a !== '0) begin n_fail++; $display("FAIL reset_a: got %h expected 0", bus.a); end
    n_checks++; if (bus.b !== '0) begin n_fail++; $display("FAIL reset_b: got %h expected 0", bus.b); end
    n_checks++; if (bus.frame_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_frame_cnt: got %0d expected 0", bus.frame_cnt); end
    n_checks++; if (bus.mm_start !== 1'b0) begin n_fail++; $display("FAIL reset_mm_start: got %b expected 0", bus.mm_start); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
  endtask

  task automatic test_load_fire();
    logic early_start;
    do_reset();
    early_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send_word(stream_q[i]);
      if (i < 7 && bus.mm_start !== 1'b0) early_start = 1'b1;
    end
    bus.in_valid = 1'b0;
    n_checks++; if (early_start !== 1'b0) begin n_fail++; $display("FAIL load_no_early_start: got %b expected 0", early_start); end
    n_checks++; if (bus.mm_start !== 1'b1) begin n_fail++; $display("FAIL load_mm_start: got %b expected 1", bus.mm_start); end
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL load_fire_ready: got %b expected 0", bus.in_ready); end
    n_checks++; if (bus.a !== EXP_A) begin n_fail++; $display("FAIL load_a: got %h expected %h", bus.a, EXP_A); end
    n_checks++; if (bus.b !== EXP_B) begin n_fail++; $display("FAIL load_b: got %h expected %h", bus.b, EXP_B); end
    tick();
    n_checks++; if (bus.mm_start !== 1'b0) begin n_fail++; $display("FAIL wait_mm_start: got %b expected 0", bus.mm_start); end
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL wait_busy: got %b expected 1", bus.busy); end
    bus.mm_done = 1'b1;
    tick();
    bus.mm_done = 1'b0;
    n_checks++; if (bus.frame_cnt !== 8'd1) begin n_fail++; $display("FAIL done_frame_cnt: got %0d expected 1", bus.frame_cnt); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL done_busy: got %b expected 0", bus.busy); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL done_in_ready: got %b expected 1", bus.in_ready); end
  endtask

  task automatic test_stall();
    do_reset();
    for (int i = 0; i < 3; i++) send_word(stream_q[i]);
    bus.in_valid = 1'b0;
    bus.in_data  = 32'hDEADBEEF;
    repeat (3) tick();
    n_checks++; if (bus.a !== 128'h3F800000_40000000_40400000_00000000) begin n_fail++; $display("FAIL stall_a: got %h expected %h", bus.a, 128'h3F800000_40000000_40400000_00000000); end
    for (int i = 3; i < 6; i++) send_word(stream_q[i]);
    bus.in_valid = 1'b0;
    bus.in_data  = 32'hCAFEF00D;
    repeat (2) tick();
    n_checks++; if (bus.b !== EXP_B_PART) begin n_fail++; $display("FAIL stall_b: got %h expected %h", bus.b, EXP_B_PART); end
    n_checks++; if (bus.mm_start !== 1'b0) begin n_fail++; $display("FAIL stall_mm_start: got %b expected 0", bus.mm_start); end
    for (int i = 6; i < 8; i++) send_word(stream_q[i]);
    bus.in_valid = 1'b0;
    n_checks++; if (bus.mm_start !== 1'b1) begin n_fail++; $display("FAIL stall_fire: got %b expected 1", bus.mm_start); end
    n_checks++; if (bus.b !== EXP_B) begin n_fail++; $display("FAIL stall_b_final: got %h expected %h", bus.b, EXP_B); end
  endtask

  task automatic test_hold_wait();
    do_reset();
    for (int i = 0; i < 8; i++) send_word(stream_q[i]);
    bus.in_data = 32'h11111111;
    repeat (3) tick();
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_in_ready: got %b expected 0", bus.in_ready); end
    n_checks++; if (bus.a !== EXP_A) begin n_fail++; $display("FAIL hold_a: got %h expected %h", bus.a, EXP_A); end
    n_checks++; if (bus.b !== EXP_B) begin n_fail++; $display("FAIL hold_b: got %h expected %h", bus.b, EXP_B); end
    bus.mm_done = 1'b1;
    tick();
    bus.mm_done = 1'b0;
    n_checks++; if (bus.frame_cnt !== 8'd1) begin n_fail++; $display("FAIL hold_frame_cnt: got %0d expected 1", bus.frame_cnt); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL hold_ready_after_done: got %b expected 1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    n_checks++; if (bus.a !== 128'h11111111_40000000_40400000_40800000) begin n_fail++; $display("FAIL hold_ninth_word: got %h expected %h", bus.a, 128'h11111111_40000000_40400000_40800000); end
    n_checks++; if (bus.b !== EXP_B) begin n_fail++; $display("FAIL hold_b_kept: got %h expected %h", bus.b, EXP_B); end
  endtask

  task automatic test_reset_midload();
    do_reset();
    for (int i = 0; i < 3; i++) send_word(stream_q[i]);
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.a !== '0) begin n_fail++; $display("FAIL midreset_a_async: got %h expected 0", bus.a); end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) send_word(stream_q[i]);
    bus.in_valid = 1'b0;
    n_checks++; if (bus.a !== EXP_A) begin n_fail++; $display("FAIL midreset_a: got %h expected %h", bus.a, EXP_A); end
    n_checks++; if (bus.b !== EXP_B) begin n_fail++; $display("FAIL midreset_b: got %h expected %h", bus.b, EXP_B); end
    n_checks++; if (bus.mm_start !== 1'b1) begin n_fail++; $display("FAIL midreset_fire: got %b expected 1", bus.mm_start); end
  endtask

  task automatic test_done_ignored();
    do_reset();
    bus.mm_done = 1'b1;
    repeat (2) tick();
    n_checks++; if (bus.frame_cnt !== 8'd0) begin n_fail++; $display("FAIL ign_idle_frame_cnt: got %0d expected 0", bus.frame_cnt); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL ign_idle_busy: got %b expected 0", bus.busy); end
    for (int i = 0; i < 8; i++) begin
      send_word(stream_q[i]);
      if (i == 5) begin
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL ign_loadb_ready: got %b expected 1", bus.in_ready); end
        n_checks++; if (bus.frame_cnt !== 8'd0) begin n_fail++; $display("FAIL ign_loadb_frame_cnt: got %0d expected 0", bus.frame_cnt); end
      end
    end
    bus.in_valid = 1'b0;
    n_checks++; if (bus.mm_start !== 1'b1) begin n_fail++; $display("FAIL ign_fire: got %b expected 1", bus.mm_start); end
    tick();
    n_checks++; if (bus.frame_cnt !== 8'd0) begin n_fail++; $display("FAIL ign_fire_frame_cnt: got %0d expected 0", bus.frame_cnt); end
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL ign_wait_busy: got %b expected 1", bus.busy); end
    tick();
    bus.mm_done = 1'b0;
    n_checks++; if (bus.frame_cnt !== 8'd1) begin n_fail++; $display("FAIL ign_wait_frame_cnt: got %0d expected 1", bus.frame_cnt); end
  endtask

  task automatic test_frame_wrap();
    do_reset();
    for (int f = 0; f < 256; f++) begin
      run_frame();
      if (f == 254) begin
        n_checks++; if (bus.frame_cnt !== 8'd255) begin n_fail++; $display("FAIL wrap_255: got %0d expected 255", bus.frame_cnt); end
      end
    end
    n_checks++; if (bus.frame_cnt !== 8'd0) begin n_fail++; $display("FAIL wrap_0: got %0d expected 0", bus.frame_cnt); end
    n_checks++; if (bus.a !== EXP_A) begin n_fail++; $display("FAIL wrap_a: got %h expected %h", bus.a, EXP_A); end
    n_checks++; if (bus.b !== EXP_B) begin n_fail++; $display("FAIL wrap_b: got %h expected %h", bus.b, EXP_B); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    stream_q = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                 32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.mm_done  = 1'b0;

    test_reset();
    $display("test_reset done: checks=%0d failures=%0d", n_checks, n_fail);
    test_load_fire();
    $display("test_load_fire done: checks=%0d failures=%0d", n_checks, n_fail);
    test_stall();
    $display("test_stall done: checks=%0d failures=%0d", n_checks, n_fail);
    test_hold_wait();
    $display("test_hold_wait done: checks=%0d failures=%0d", n_checks, n_fail);
    test_reset_midload();
    $display("test_reset_midload done: checks=%0d failures=%0d", n_checks, n_fail);
    test_done_ignored();
    $display("test_done_ignored done: checks=%0d failures=%0d", n_checks, n_fail);
    test_frame_wrap();
    $display("test_frame_wrap done: checks=%0d failures=%0d", n_checks, n_fail);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mat_loader.md
MAT_LOADER -- requirements
Module: mat_loader

Interface
REQ-001 S, 32, float element width in bits.
REQ-002 H, 2, rows of matrix A.
REQ-003 C, 2, common dimension: columns of A, rows of B.
REQ-004 W, 2, columns of matrix B.
REQ-005 clk  input  1  clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 in_valid  input  1  in_data carries a valid float element.
REQ-008 in_ready  output  1  loader accepts an element this cycle.
REQ-009 in_data  input  S  float element, A elements first, then B elements.
REQ-010 mm_start  output  1  one-cycle start pulse to the downstream matrix multiplier.
REQ-011 mm_done  input  1  downstream multiplier has finished the current product.
REQ-012 a  output  S*H*C  packed matrix A, row-major, element (0,0) in the most-significant slice.
REQ-013 b  output  S*C*W  packed matrix B, row-major, element (0,0) in the most-significant slice.
REQ-014 busy  output  1  high in FIRE and WAIT.
REQ-015 frame_cnt  output  8  count of completed products, wraps 255 -> 0.

Function
REQ-016 States SHALL be LOAD_A, LOAD_B, FIRE and WAIT, with one element counter n.
REQ-017 A handshake SHALL occur on a rising edge where in_valid and in_ready are both 1; no other condition consumes in_data.
REQ-018 in_ready SHALL be 1 in LOAD_A and LOAD_B and 0 in FIRE and WAIT, decoded from state only.
REQ-019 LOAD_A: handshake n (0..H*C-1) SHALL write in_data to A slice n counted from the MSB, i.e. bits [S*(H*C-n)-1 : S*(H*C-n-1)].
REQ-020 On handshake n=H*C-1 in LOAD_A, the block SHALL clear n and enter LOAD_B.
REQ-021 LOAD_B: handshake n (0..C*W-1) SHALL write in_data to B slot n counted from the MSB, with the mapping given under REQ-032/033.
REQ-022 On handshake n=C*W-1 in LOAD_B, the block SHALL clear n and enter FIRE.
REQ-023 FIRE SHALL last exactly one cycle with mm_start=1, then enter WAIT; mm_start SHALL be 0 in every other state.
REQ-024 WAIT: on mm_done=1 the block SHALL increment frame_cnt modulo 256 and enter LOAD_A.
REQ-025 mm_done SHALL be ignored in LOAD_A, LOAD_B and FIRE.
REQ-026 a and b SHALL stay unchanged from the last B handshake until the next A handshake; slices not yet rewritten keep their previous values.
REQ-027 in_valid low in a load state SHALL stall without changing n, a or b.
REQ-028 Latency: mm_start SHALL rise on the first clock edge after the final B handshake.

Reset
REQ-029 While rst_n=0: state LOAD_A, n=0, a=0, b=0, mm_start=0, frame_cnt=0, busy=0, asynchronously.
REQ-030 Reset in any state, including mid-load or WAIT, SHALL abandon the frame; the next accepted element is A element (0,0).
REQ-031 in_ready SHALL be 1 from the first cycle after rst_n deasserts.

Configuration
REQ-032 Macro MAT_LOADER_TRANSPOSE_B_EN defined: the B stream SHALL be column-major, and handshake n writes element (k=n mod C, j=n div C) into row-major slot k*W+j.
REQ-033 Macro undefined: the B stream SHALL be row-major, and handshake n writes slot n directly.

Verification (H=C=W=2, S=32)
REQ-034 Stream 3F800000, 40000000, 40400000, 40800000, 40A00000, 40C00000, 40E00000, 41000000, in_valid always high -> a=3F800000_40000000_40400000_40800000, b=40A00000_40C00000_40E00000_41000000 (macro off); mm_start high exactly one cycle, the cycle after the 8th handshake.
REQ-035 Same stream with MAT_LOADER_TRANSPOSE_B_EN -> b=40A00000_40E00000_40C00000_41000000.
REQ-036 in_valid held high with a 9th word through WAIT -> in_ready=0, a and b unchanged; mm_done pulse -> frame_cnt=1, 9th word accepted as A(0,0) next cycle.
REQ-037 rst_n pulsed low after 3 A handshakes -> a=0, n=0; a fresh 8-word stream produces the REQ-034 result.
REQ-038 mm_done=1 during LOAD_A/LOAD_B -> no state or frame_cnt change; 256 completed frames -> frame_cnt=0.
